sq_mt_drain: RTL and testbench
==============================

Name: sq_mt_drain

Overview:
- Parametrised, multi-thread successor of the two-thread store queue.
- Holds dispatched stores per thread in program order and computes the effective address at dispatch.
- Captures late store data from the CDB.
- Marks stores committed when the ROB retires them, then drains committed stores to the data-memory port one per cycle under a valid/ready handshake with round-robin thread arbitration.
- Sits between dispatch/ROB and the D-cache store port.

Parameters:
- NUM_THREADS, 2, hardware threads; each thread has a private circular queue.
- SQ_DEPTH, 8, entries per thread; power of two.
- DISP_WIDTH, 2, stores dispatched per cycle, all to one thread.
- CMT_WIDTH, 2, ROB commit ports per thread.
- CDB_WIDTH, 2, CDB broadcast ports.
- ROB_IDX_W, 6, ROB index width, including the wrap bit.
- PRF_W, 6, physical tag width.
- ADDR_W, 64, address width.
- DATA_W, 64, store data width.
- TID_W, max(1,$clog2(NUM_THREADS)), thread id width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; the queue is held in reset while 0.
- disp_valid  in  DISP_WIDTH  per-slot store dispatch; slot 0 is older.
- disp_thread  in  TID_W  thread owning this cycle's dispatch.
- disp_base  in  DISP_WIDTH*DATA_W  base operand.
- disp_offset  in  DISP_WIDTH*DATA_W  offset operand.
- disp_rob_idx  in  DISP_WIDTH*ROB_IDX_W  ROB index of the store.
- disp_data  in  DISP_WIDTH*DATA_W  store data.
- disp_data_valid  in  DISP_WIDTH  1 = disp_data is valid; 0 = wait on disp_data_tag.
- disp_data_tag  in  DISP_WIDTH*PRF_W  producer tag of the store data.
- cdb_valid  in  CDB_WIDTH  broadcast valid.
- cdb_tag  in  CDB_WIDTH*PRF_W  broadcast tag.
- cdb_value  in  CDB_WIDTH*DATA_W  broadcast value.
- commit_valid  in  NUM_THREADS*CMT_WIDTH  ROB retire valid, per thread per port.
- commit_rob_idx  in  NUM_THREADS*CMT_WIDTH*ROB_IDX_W  ROB index being retired.
- mispredict  in  NUM_THREADS  thread branch mispredict at ROB head.
- commit_ack  out  NUM_THREADS*CMT_WIDTH  retired instruction was a store held here.
- mem_st_valid  out  1  store request to memory.
- mem_st_addr  out  ADDR_W  store address.
- mem_st_data  out  DATA_W  store data.
- mem_st_thread  out  TID_W  owning thread.
- mem_st_ready  in  1  memory accepts the request.
- full  out  NUM_THREADS  fewer than DISP_WIDTH free entries.
- empty  out  NUM_THREADS  no entries at all, committed or not.

Behaviour:
- Pointers per thread: head (oldest undrained), cmt (oldest uncommitted), tail (next free). Each is $clog2(SQ_DEPTH)+1 bits, with the wrap bit used for full/empty.
- Invariant: head <= cmt <= tail. count = tail - head.
- Entry fields: addr, data, data_valid, data_tag, rob_idx.
- Reset (reset=0, async):
  - All pointers and the round-robin pointer go to 0; all data_valid bits clear.
  - mem_st_valid=0, mem_st_addr=0, mem_st_data=0, mem_st_thread=0.
  - commit_ack=0, full=0, empty=all ones.
  - Reset mid-drain discards the outstanding request.
- Dispatch:
  - Valid slots are written in slot order at tail, tail+1, ...; gaps in disp_valid are compacted.
  - addr = disp_base + disp_offset, truncated mod 2^ADDR_W.
  - Dispatch to a thread with full=1 is ignored; no pointer or entry change.
- Data capture:
  - Every entry with data_valid=0 compares data_tag against all valid CDB ports each cycle; a match loads cdb_value and sets data_valid at the next edge.
  - A dispatching slot with data_valid=0 also checks the CDB in the same cycle (bypass).
  - If several ports match, the lowest-numbered port wins.
- Commit (combinational ack, state updates at the edge):
  - Port 0 of thread t acks if the entry at cmt[t] exists, its rob_idx equals the port's index, and its data_valid=1.
  - Port k acks only if ports 0..k-1 acked and the entry at cmt+k matches the same way.
  - cmt advances by the number of acks.
  - A non-matching commit (the ROB retired a non-store) produces ack=0 and no change.
- Drain:
  - When mem_st_valid=0, select the first thread with head != cmt, searching round-robin starting after the last-served thread.
  - The selected thread's head entry drives mem_st_addr/data/thread combinationally.
  - While valid && !ready, the selection and outputs are held stable.
  - On valid && ready, head of that thread increments at the edge and the round-robin pointer moves past that thread.
  - Throughput is one store per cycle with ready tied high.
- Mispredict[t]:
  - At the edge, tail[t] <= cmt[t] after applying that cycle's commits, squashing all uncommitted entries.
  - Dispatch to t in the same cycle is ignored.
  - Committed entries keep draining.
- Simultaneous events:
  - Dispatch, commit, CDB capture and drain in one cycle are all applied.
  - full/empty are computed from the registered pointers only.
  - Wrap-around relies on the pointer wrap bit: full when tail - head > SQ_DEPTH - DISP_WIDTH.

Test Plan:
- Reset, then dispatch thread 0 with slot0 {base=1, off=F0, data=F, rob=12} and slot1 {base=2, off=F0, data=F0, rob=13}; commit idx 12,13 next cycle, ready=1.
  - Required: commit_ack=2'b11; then mem_st addr F1/data F, then F2/F0 on consecutive cycles; empty[0]=1 after.
- Dispatch with data_valid=0, tag 5; commit rob idx attempted before the CDB broadcast.
  - Required: ack=0.
  - After cdb tag 5 with value AB: commit acks; drained data=AB.
- Hold mem_st_ready=0 for 3 cycles with a committed store.
  - Required: mem_st_valid=1 and addr/data stable throughout; a single handshake follows.
- Threads 0 and 1 each with 2 committed stores, ready=1.
  - Required: drain order T0, T1, T0, T1.
- Dispatch 4 stores to thread 1, commit the first, then assert mispredict[1].
  - Required: tail=cmt=1; only one store drains; empty[1]=1 after the drain.
- Fill thread 0 to 7 of 8 entries.
  - Required: full[0]=1; a further dispatch is ignored; pointers wrap correctly after a drain and refill.

Source files
------------

// File: rtl/sq_mt_drain.sv
`timescale 1ns/1ps
// sq_mt_drain: multi-thread store queue with commit tracking and memory drain.
// Each thread owns a circular queue. Stores enter at tail with their effective
// address. Data is taken from dispatch or captured later from the CDB. Stores
// become committed when the ROB retires them. Committed stores then leave
// through a single valid/ready memory port, with round-robin thread choice.
//
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   disp_*            up to DISP_WIDTH stores per cycle to disp_thread (slot 0 oldest)
//   cdb_*             CDB_WIDTH result broadcasts for late store data
//   commit_*          per-thread ROB retire ports; mispredict squashes uncommitted
//   commit_ack        retired instruction was a store held here
//   mem_st_*          store request to the D-cache (valid/ready)
//   full, empty       per-thread occupancy flags, taken from registered pointers
module sq_mt_drain #(
  parameter int NUM_THREADS = 2,
  parameter int SQ_DEPTH    = 8,
  parameter int DISP_WIDTH  = 2,
  parameter int CMT_WIDTH   = 2,
  parameter int CDB_WIDTH   = 2,
  parameter int ROB_IDX_W   = 6,
  parameter int PRF_W       = 6,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [DISP_WIDTH-1:0]                    disp_valid,
  input  logic [TID_W-1:0]                         disp_thread,
  input  logic [DISP_WIDTH*DATA_W-1:0]             disp_base,
  input  logic [DISP_WIDTH*DATA_W-1:0]             disp_offset,
  input  logic [DISP_WIDTH*ROB_IDX_W-1:0]          disp_rob_idx,
  input  logic [DISP_WIDTH*DATA_W-1:0]             disp_data,
  input  logic [DISP_WIDTH-1:0]                    disp_data_valid,
  input  logic [DISP_WIDTH*PRF_W-1:0]              disp_data_tag,
  input  logic [CDB_WIDTH-1:0]                     cdb_valid,
  input  logic [CDB_WIDTH*PRF_W-1:0]               cdb_tag,
  input  logic [CDB_WIDTH*DATA_W-1:0]              cdb_value,
  input  logic [NUM_THREADS*CMT_WIDTH-1:0]         commit_valid,
  input  logic [NUM_THREADS*CMT_WIDTH*ROB_IDX_W-1:0] commit_rob_idx,
  input  logic [NUM_THREADS-1:0]                   mispredict,
  output logic [NUM_THREADS*CMT_WIDTH-1:0]         commit_ack,
  output logic                                     mem_st_valid,
  output logic [ADDR_W-1:0]                        mem_st_addr,
  output logic [DATA_W-1:0]                        mem_st_data,
  output logic [TID_W-1:0]                         mem_st_thread,
  input  logic                                     mem_st_ready,
  output logic [NUM_THREADS-1:0]                   full,
  output logic [NUM_THREADS-1:0]                   empty
);

  localparam int IDX_W  = $clog2(SQ_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int DCNT_W = $clog2(DISP_WIDTH + 1);

  logic [PTR_W-1:0] head_q [NUM_THREADS];
  logic [PTR_W-1:0] cmt_q  [NUM_THREADS];
  logic [PTR_W-1:0] tail_q [NUM_THREADS];
  logic [TID_W-1:0] rr_q;
  logic [TID_W-1:0] hold_tid_q;
  logic             hold_q;

  logic [ADDR_W-1:0]    e_addr [NUM_THREADS][SQ_DEPTH];
  logic [DATA_W-1:0]    e_data [NUM_THREADS][SQ_DEPTH];
  logic                 e_dv   [NUM_THREADS][SQ_DEPTH];
  logic [PRF_W-1:0]     e_tag  [NUM_THREADS][SQ_DEPTH];
  logic [ROB_IDX_W-1:0] e_rob  [NUM_THREADS][SQ_DEPTH];

  logic                  disp_ok;
  logic [DISP_WIDTH-1:0] slot_we;
  logic [DISP_WIDTH-1:0] slot_dv;
  logic [IDX_W-1:0]      slot_idx  [DISP_WIDTH];
  logic [DATA_W-1:0]     slot_data [DISP_WIDTH];
  logic [DCNT_W-1:0]     disp_cnt;

  logic                  cap_hit [NUM_THREADS][SQ_DEPTH];
  logic [DATA_W-1:0]     cap_val [NUM_THREADS][SQ_DEPTH];
  logic [PTR_W-1:0]      cmt_adv [NUM_THREADS];

  logic                  cand_any;
  logic [TID_W-1:0]      cand_tid;
  logic [TID_W-1:0]      sel_tid;
  logic [IDX_W-1:0]      sel_idx;
  logic                  drain_fire;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      full[t]  = (tail_q[t] - head_q[t]) > PTR_W'(SQ_DEPTH - DISP_WIDTH);
      empty[t] = (tail_q[t] == head_q[t]);
    end
  end

  // Dispatch: valid slots are packed at tail. A slot still waiting on data
  // also looks at this cycle's CDB. The lowest CDB port is checked last so it
  // has priority.
  always_comb begin
    disp_ok  = !full[disp_thread] && !mispredict[disp_thread];
    disp_cnt = '0;
    for (int s = 0; s < DISP_WIDTH; s++) begin
      slot_we[s]   = 1'b0;
      slot_idx[s]  = tail_q[disp_thread][IDX_W-1:0] + IDX_W'(disp_cnt);
      if (disp_valid[s] && disp_ok) begin
        slot_we[s] = 1'b1;
        disp_cnt   = disp_cnt + DCNT_W'(1);
      end
      slot_dv[s]   = disp_data_valid[s];
      slot_data[s] = disp_data[s*DATA_W +: DATA_W];
      for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
        if (!disp_data_valid[s] && cdb_valid[p] &&
            cdb_tag[p*PRF_W +: PRF_W] == disp_data_tag[s*PRF_W +: PRF_W]) begin
          slot_dv[s]   = 1'b1;
          slot_data[s] = cdb_value[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Late data capture for resident entries; lowest matching port wins.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int d = 0; d < SQ_DEPTH; d++) begin
        cap_hit[t][d] = 1'b0;
        cap_val[t][d] = '0;
        for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
          if (!e_dv[t][d] && cdb_valid[p] && cdb_tag[p*PRF_W +: PRF_W] == e_tag[t][d]) begin
            cap_hit[t][d] = 1'b1;
            cap_val[t][d] = cdb_value[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Commit: acks form an unbroken prefix starting at port 0. A port only acks
  // an entry that exists, matches the ROB index and already has its data.
  always_comb begin
    logic             run;
    logic [PTR_W-1:0] avail;
    logic [IDX_W-1:0] cidx;
    for (int t = 0; t < NUM_THREADS; t++) begin
      run        = 1'b1;
      avail      = tail_q[t] - cmt_q[t];
      cmt_adv[t] = '0;
      for (int k = 0; k < CMT_WIDTH; k++) begin
        cidx = cmt_q[t][IDX_W-1:0] + IDX_W'(k);
        run  = run && commit_valid[t*CMT_WIDTH+k] && (PTR_W'(k) < avail) && e_dv[t][cidx] &&
               (e_rob[t][cidx] == commit_rob_idx[(t*CMT_WIDTH+k)*ROB_IDX_W +: ROB_IDX_W]);
        commit_ack[t*CMT_WIDTH+k] = run;
        if (run) cmt_adv[t] = cmt_adv[t] + PTR_W'(1);
      end
    end
  end

  // Drain: rr_q is the first thread to consider. A stalled request keeps its
  // thread in hold_tid_q. The head entry is committed, so it cannot change
  // while the request is held.
  always_comb begin
    int t;
    cand_any = 1'b0;
    cand_tid = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      t = (int'(rr_q) + i) % NUM_THREADS;
      if (!cand_any && head_q[t] != cmt_q[t]) begin
        cand_any = 1'b1;
        cand_tid = TID_W'(t);
      end
    end
    sel_tid       = hold_q ? hold_tid_q : cand_tid;
    mem_st_valid  = hold_q || cand_any;
    sel_idx       = head_q[sel_tid][IDX_W-1:0];
    mem_st_addr   = '0;
    mem_st_data   = '0;
    mem_st_thread = '0;
    if (mem_st_valid) begin
      mem_st_addr   = e_addr[sel_tid][sel_idx];
      mem_st_data   = e_data[sel_tid][sel_idx];
      mem_st_thread = sel_tid;
    end
  end

  assign drain_fire = mem_st_valid && mem_st_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        head_q[t] <= '0;
        cmt_q[t]  <= '0;
        tail_q[t] <= '0;
        for (int d = 0; d < SQ_DEPTH; d++) e_dv[t][d] <= 1'b0;
      end
      rr_q       <= '0;
      hold_q     <= 1'b0;
      hold_tid_q <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        cmt_q[t] <= cmt_q[t] + cmt_adv[t];
        if (mispredict[t])
          tail_q[t] <= cmt_q[t] + cmt_adv[t];
        else if (disp_ok && disp_thread == TID_W'(t))
          tail_q[t] <= tail_q[t] + PTR_W'(disp_cnt);
        if (drain_fire && sel_tid == TID_W'(t))
          head_q[t] <= head_q[t] + PTR_W'(1);
        for (int d = 0; d < SQ_DEPTH; d++) begin
          if (cap_hit[t][d]) e_dv[t][d] <= 1'b1;
          for (int s = 0; s < DISP_WIDTH; s++)
            if (slot_we[s] && disp_thread == TID_W'(t) && slot_idx[s] == IDX_W'(d))
              e_dv[t][d] <= slot_dv[s];
        end
      end
      if (drain_fire) rr_q <= TID_W'((int'(sel_tid) + 1) % NUM_THREADS);
      hold_q     <= mem_st_valid && !mem_st_ready;
      hold_tid_q <= sel_tid;
    end
  end

  // Payload storage needs no reset; e_dv and the pointers qualify every use.
  always_ff @(posedge clock) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int d = 0; d < SQ_DEPTH; d++) begin
        if (cap_hit[t][d]) e_data[t][d] <= cap_val[t][d];
        for (int s = 0; s < DISP_WIDTH; s++) begin
          if (slot_we[s] && disp_thread == TID_W'(t) && slot_idx[s] == IDX_W'(d)) begin
            e_addr[t][d] <= ADDR_W'(disp_base[s*DATA_W +: DATA_W]) +
                            ADDR_W'(disp_offset[s*DATA_W +: DATA_W]);
            e_data[t][d] <= slot_data[s];
            e_tag[t][d]  <= disp_data_tag[s*PRF_W +: PRF_W];
            e_rob[t][d]  <= disp_rob_idx[s*ROB_IDX_W +: ROB_IDX_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sq_mt_drain.sv
`timescale 1ns/1ps
// Directed bench for sq_mt_drain: a table of single-store vectors plus
// hand-written multi-cycle sequences (hold, arbitration, mispredict, full/wrap).
module tb_sq_mt_drain;
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    disp_valid;
  logic [0:0]    disp_thread;
  logic [127:0]  disp_base, disp_offset, disp_data;
  logic [11:0]   disp_rob_idx, disp_data_tag;
  logic [1:0]    disp_data_valid;
  logic [1:0]    cdb_valid;
  logic [11:0]   cdb_tag;
  logic [127:0]  cdb_value;
  logic [3:0]    commit_valid;
  logic [23:0]   commit_rob_idx;
  logic [1:0]    mispredict;
  logic [3:0]    commit_ack;
  logic          mem_st_valid;
  logic [63:0]   mem_st_addr, mem_st_data;
  logic [0:0]    mem_st_thread;
  logic          mem_st_ready;
  logic [1:0]    full, empty;

  sq_mt_drain dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_thread(disp_thread),
    .disp_base(disp_base), .disp_offset(disp_offset),
    .disp_rob_idx(disp_rob_idx), .disp_data(disp_data),
    .disp_data_valid(disp_data_valid), .disp_data_tag(disp_data_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .mispredict(mispredict), .commit_ack(commit_ack),
    .mem_st_valid(mem_st_valid), .mem_st_addr(mem_st_addr),
    .mem_st_data(mem_st_data), .mem_st_thread(mem_st_thread),
    .mem_st_ready(mem_st_ready), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          th;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } drn_t;
  drn_t drained[$];

  typedef struct {
    int          th;
    logic [63:0] base, off, data;
    logic [5:0]  rob;
    logic        dv;
    logic [5:0]  tag;
    logic        byp;
    logic [1:0]  cv;
    logic [63:0] c0, c1;
    logic [63:0] exp_addr, exp_data;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (reset && mem_st_valid && mem_st_ready)
      drained.push_back('{int'(mem_st_thread), mem_st_addr, mem_st_data, cyc});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    disp_valid = '0; disp_thread = '0; disp_base = '0; disp_offset = '0;
    disp_data = '0; disp_rob_idx = '0; disp_data_valid = '0; disp_data_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    commit_valid = '0; commit_rob_idx = '0; mispredict = '0;
  endtask

  task automatic slot(input int s, input int th, input logic [63:0] b, input logic [63:0] o,
                      input logic [63:0] d, input logic [5:0] rob, input logic dv,
                      input logic [5:0] tag);
    disp_valid[s] = 1'b1;
    disp_thread = th[0];
    disp_base[s*64 +: 64] = b;
    disp_offset[s*64 +: 64] = o;
    disp_data[s*64 +: 64] = d;
    disp_rob_idx[s*6 +: 6] = rob;
    disp_data_valid[s] = dv;
    disp_data_tag[s*6 +: 6] = tag;
  endtask

  task automatic cmt(input int th, input int k, input logic [5:0] rob);
    commit_valid[th*2+k] = 1'b1;
    commit_rob_idx[(th*2+k)*6 +: 6] = rob;
  endtask

  task automatic wait_drains(input int n);
    for (int i = 0; i < 40 && drained.size() < n; i++) tick();
  endtask

  task automatic pop_chk(input string nm, input int th, input logic [63:0] a,
                         input logic [63:0] d, output int c);
    drn_t r;
    c = -1;
    if (drained.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s no store drained, required addr=%h", nm, a);
    end else begin
      r = drained.pop_front();
      c = r.cyc;
      chk({nm, "_thread"}, 64'(r.th), 64'(th));
      chk({nm, "_addr"}, r.addr, a);
      chk({nm, "_data"}, r.data, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    vec_t v;
    clr();
    mem_st_ready = 1'b1;
    //          th base                 off                   data      rob dv tag byp cv     c0      c1      exp_addr exp_data
    vecs[0] = '{0, 64'h1000,            64'h24,               64'hDEAD, 1, 1, 0, 0, 2'b00, 64'h0,  64'h0,  64'h1024, 64'hDEAD};
    vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,            64'h1234, 2, 1, 0, 0, 2'b00, 64'h0,  64'h0,  64'h1,    64'h1234};
    vecs[2] = '{0, 64'h10,              64'h10,               64'h0,    3, 0, 9, 0, 2'b10, 64'h0,  64'h77, 64'h20,   64'h77};
    vecs[3] = '{1, 64'h30,              64'h1,                64'h0,    4, 0, 3, 0, 2'b11, 64'hAA, 64'hBB, 64'h31,   64'hAA};
    vecs[4] = '{0, 64'h40,              64'h8,                64'h0,    5, 0, 4, 1, 2'b01, 64'hCC, 64'h0,  64'h48,   64'hCC};
    vecs[5] = '{1, 64'h8000,            64'hFFFF_FFFF_FFFF_F000, 64'h99, 6, 1, 0, 0, 2'b00, 64'h0,  64'h0,  64'h7000, 64'h99};

    // reset state
    #12;
    chk("rst_valid", 64'(mem_st_valid), 64'h0);
    chk("rst_addr", mem_st_addr, 64'h0);
    chk("rst_data", mem_st_data, 64'h0);
    chk("rst_thread", 64'(mem_st_thread), 64'h0);
    chk("rst_ack", 64'(commit_ack), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_empty", 64'(empty), 64'h3);
    tick();
    reset = 1'b1;

    // two-store dispatch, dual commit, back-to-back drain
    slot(0, 0, 64'h1, 64'hF0, 64'hF, 6'h12, 1'b1, 6'h0);
    slot(1, 0, 64'h2, 64'hF0, 64'hF0, 6'h13, 1'b1, 6'h0);
    tick(); clr();
    cmt(0, 0, 6'h12); cmt(0, 1, 6'h13);
    #3 chk("t1_ack", 64'(commit_ack), 64'h3);
    tick(); clr();
    wait_drains(2);
    pop_chk("t1_d0", 0, 64'hF1, 64'hF, c1);
    pop_chk("t1_d1", 0, 64'hF2, 64'hF0, c2);
    chk("t1_consecutive", 64'(c2 - c1), 64'h1);
    tick();
    chk("t1_empty", 64'(empty[0]), 64'h1);

    // late data from CDB
    slot(0, 0, 64'h100, 64'h0, 64'h0, 6'd20, 1'b0, 6'd5);
    tick(); clr();
    cmt(0, 0, 6'd20);
    #3 chk("t2_ack_early", 64'(commit_ack), 64'h0);
    tick(); clr();
    cdb_valid = 2'b01; cdb_tag[5:0] = 6'd5; cdb_value[63:0] = 64'hAB;
    tick(); clr();
    cmt(0, 0, 6'd20);
    #3 chk("t2_ack_late", 64'(commit_ack), 64'h1);
    tick(); clr();
    wait_drains(1);
    pop_chk("t2_drain", 0, 64'h100, 64'hAB, c1);

    // backpressure hold
    mem_st_ready = 1'b0;
    slot(0, 0, 64'h200, 64'h4, 64'h55, 6'd21, 1'b1, 6'h0);
    tick(); clr();
    cmt(0, 0, 6'd21);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("t3_valid%0d", i), 64'(mem_st_valid), 64'h1);
      chk($sformatf("t3_addr%0d", i), mem_st_addr, 64'h204);
      chk($sformatf("t3_data%0d", i), mem_st_data, 64'h55);
      tick();
    end
    mem_st_ready = 1'b1;
    wait_drains(1);
    pop_chk("t3_drain", 0, 64'h204, 64'h55, c1);
    tick();
    chk("t3_single", 64'(drained.size()), 64'h0);
    chk("t3_idle", 64'(mem_st_valid), 64'h0);

    // round-robin between threads
    mem_st_ready = 1'b0;
    slot(0, 0, 64'h300, 64'h0, 64'hA0, 6'd22, 1'b1, 6'h0);
    slot(1, 0, 64'h301, 64'h0, 64'hA1, 6'd23, 1'b1, 6'h0);
    tick(); clr();
    slot(0, 1, 64'h400, 64'h0, 64'hB0, 6'd30, 1'b1, 6'h0);
    slot(1, 1, 64'h401, 64'h0, 64'hB1, 6'd31, 1'b1, 6'h0);
    tick(); clr();
    cmt(0, 0, 6'd22); cmt(0, 1, 6'd23);
    tick(); clr();
    cmt(1, 0, 6'd30); cmt(1, 1, 6'd31);
    #3 chk("t4_ack_t1", 64'(commit_ack), 64'hC);
    tick(); clr();
    mem_st_ready = 1'b1;
    wait_drains(4);
    pop_chk("t4_d0", 0, 64'h300, 64'hA0, c1);
    pop_chk("t4_d1", 1, 64'h400, 64'hB0, c1);
    pop_chk("t4_d2", 0, 64'h301, 64'hA1, c1);
    pop_chk("t4_d3", 1, 64'h401, 64'hB1, c1);

    // mispredict squashes uncommitted stores of thread 1
    slot(0, 1, 64'h500, 64'h0, 64'hC0, 6'd40, 1'b1, 6'h0);
    slot(1, 1, 64'h501, 64'h0, 64'hC1, 6'd41, 1'b1, 6'h0);
    tick(); clr();
    slot(0, 1, 64'h502, 64'h0, 64'hC2, 6'd42, 1'b1, 6'h0);
    slot(1, 1, 64'h503, 64'h0, 64'hC3, 6'd43, 1'b1, 6'h0);
    tick(); clr();
    cmt(1, 0, 6'd40);
    #3 chk("t5_ack", 64'(commit_ack), 64'h4);
    tick(); clr();
    mispredict = 2'b10;
    slot(0, 1, 64'h504, 64'h0, 64'hC4, 6'd44, 1'b1, 6'h0);
    tick(); clr();
    cmt(1, 0, 6'd41);
    #3 chk("t5_ack_squashed", 64'(commit_ack), 64'h0);
    tick(); clr();
    cmt(1, 0, 6'd44);
    #3 chk("t5_ack_ignored_disp", 64'(commit_ack), 64'h0);
    tick(); clr();
    repeat (4) tick();
    chk("t5_count", 64'(drained.size()), 64'h1);
    pop_chk("t5_drain", 1, 64'h500, 64'hC0, c1);
    chk("t5_empty", 64'(empty[1]), 64'h1);

    // table-driven single-store vectors
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      drained.delete();
      slot(0, v.th, v.base, v.off, v.data, v.rob, v.dv, v.tag);
      if (v.byp) begin
        cdb_valid = v.cv; cdb_tag = {v.tag, v.tag}; cdb_value = {v.c1, v.c0};
      end
      tick(); clr();
      if (!v.dv && !v.byp) begin
        cdb_valid = v.cv; cdb_tag = {v.tag, v.tag}; cdb_value = {v.c1, v.c0};
        tick(); clr();
      end
      cmt(v.th, 0, v.rob);
      #3 chk($sformatf("vec%0d_ack", i), 64'(commit_ack[v.th*2]), 64'h1);
      tick(); clr();
      wait_drains(1);
      pop_chk($sformatf("vec%0d", i), v.th, v.exp_addr, v.exp_data, c1);
    end

    // fill thread 0 to 7 of 8 entries, then drain and refill across the wrap
    drained.delete();
    for (int i = 0; i < 3; i++) begin
      slot(0, 0, 64'h600 + 64'(2*i), 64'h0, 64'hD0 + 64'(2*i), 6'(50 + 2*i), 1'b1, 6'h0);
      slot(1, 0, 64'h601 + 64'(2*i), 64'h0, 64'hD1 + 64'(2*i), 6'(51 + 2*i), 1'b1, 6'h0);
      tick(); clr();
    end
    chk("t6_full_at6", 64'(full[0]), 64'h0);
    slot(0, 0, 64'h606, 64'h0, 64'hD6, 6'd56, 1'b1, 6'h0);
    tick(); clr();
    chk("t6_full_at7", 64'(full[0]), 64'h1);
    chk("t6_not_empty", 64'(empty[0]), 64'h0);
    slot(0, 0, 64'h6F0, 64'h0, 64'hEE, 6'd57, 1'b1, 6'h0);
    slot(1, 0, 64'h6F1, 64'h0, 64'hEF, 6'd58, 1'b1, 6'h0);
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      cmt(0, 0, 6'(50 + 2*i)); cmt(0, 1, 6'(51 + 2*i));
      #3 chk($sformatf("t6_ack%0d", i), 64'(commit_ack[1:0]), 64'h3);
      tick(); clr();
    end
    cmt(0, 0, 6'd56); cmt(0, 1, 6'd57);
    #3 chk("t6_ack_last", 64'(commit_ack[1:0]), 64'h1);
    tick(); clr();
    wait_drains(7);
    repeat (3) tick();
    chk("t6_count", 64'(drained.size()), 64'h7);
    for (int i = 0; i < 7; i++)
      pop_chk($sformatf("t6_d%0d", i), 0, 64'h600 + 64'(i), 64'hD0 + 64'(i), c1);
    chk("t6_empty", 64'(empty[0]), 64'h1);
    chk("t6_full_clear", 64'(full[0]), 64'h0);
    slot(0, 0, 64'h700, 64'h0, 64'hF7, 6'd60, 1'b1, 6'h0);
    slot(1, 0, 64'h701, 64'h0, 64'hF8, 6'd61, 1'b1, 6'h0);
    tick(); clr();
    cmt(0, 0, 6'd60); cmt(0, 1, 6'd61);
    #3 chk("t6_wrap_ack", 64'(commit_ack[1:0]), 64'h3);
    tick(); clr();
    wait_drains(2);
    pop_chk("t6_wrap0", 0, 64'h700, 64'hF7, c1);
    pop_chk("t6_wrap1", 0, 64'h701, 64'hF8, c1);
    tick();
    chk("t6_wrap_empty", 64'(empty[0]), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
